// File: rtl/ppu_oam_dma.sv
// Sprite DMA: a write to DMA_REG_ADDR copies 256 bytes from CPU page P into OAM at OAMADDR+n.
// Optional PPU_OAM_DMA_ALIGN_EN inserts one ALIGN cycle when the grant lands on an odd cycle.
module ppu_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter int unsigned XFER_LEN     = 256
) (
    input  logic        i_cpu_clk,
    input  logic        i_cpu_rstn,
    input  logic [15:0] i_bus_addr,
    input  logic        i_bus_wn,
    input  logic [7:0]  i_bus_wdata,
    input  logic [7:0]  i_oam_base,
    output logic        o_spr_req,
    input  logic        i_spr_gnt,
    output logic [15:0] o_spr_addr,
    output logic        o_spr_wn,
    output logic [7:0]  o_spr_wdata,
    input  logic [7:0]  i_spr_rdata,
    output logic [7:0]  o_oam_addr,
    output logic        o_oam_we,
    output logic [7:0]  o_oam_wdata,
    output logic        o_busy
);

    localparam logic [7:0] LastCnt = 8'(XFER_LEN - 1);

`ifdef PPU_OAM_DMA_ALIGN_EN
    typedef enum logic [2:0] {StIdle, StReq, StAlign, StRd, StWr, StDone} state_e;
    logic parity_q;
`else
    typedef enum logic [2:0] {StIdle, StReq, StRd, StWr, StDone} state_e;
`endif

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [7:0] page_q;
    logic [7:0] base_q;

    // Read-only master port.
    assign o_spr_wn    = 1'b1;
    assign o_spr_wdata = 8'h00;

    always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn) begin
            state_q     <= StIdle;
            cnt_q       <= 8'h00;
            page_q      <= 8'h00;
            base_q      <= 8'h00;
            o_spr_req   <= 1'b0;
            o_spr_addr  <= 16'h0000;
            o_oam_addr  <= 8'h00;
            o_oam_we    <= 1'b0;
            o_oam_wdata <= 8'h00;
            o_busy      <= 1'b0;
`ifdef PPU_OAM_DMA_ALIGN_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            o_oam_we <= 1'b0;
`ifdef PPU_OAM_DMA_ALIGN_EN
            parity_q <= ~parity_q;
`endif
            case (state_q)
                StIdle: begin
                    if (!i_bus_wn && (i_bus_addr == DMA_REG_ADDR)) begin
                        page_q    <= i_bus_wdata;
                        base_q    <= i_oam_base;
                        cnt_q     <= 8'h00;
                        o_spr_req <= 1'b1;
                        o_busy    <= 1'b1;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    if (i_spr_gnt) begin
`ifdef PPU_OAM_DMA_ALIGN_EN
                        if (parity_q) begin
                            state_q <= StAlign;
                        end else begin
                            o_spr_addr <= {page_q, cnt_q};
                            state_q    <= StRd;
                        end
`else
                        o_spr_addr <= {page_q, cnt_q};
                        state_q    <= StRd;
`endif
                    end
                end
`ifdef PPU_OAM_DMA_ALIGN_EN
                StAlign: begin
                    o_spr_addr <= {page_q, cnt_q};
                    state_q    <= StRd;
                end
`endif
                // Without grant the read address is held and no OAM write is issued.
                StRd: begin
                    if (i_spr_gnt) begin
                        state_q <= StWr;
                    end
                end
                StWr: begin
                    o_oam_wdata <= i_spr_rdata;
                    o_oam_addr  <= base_q + cnt_q;
                    o_oam_we    <= 1'b1;
                    if (cnt_q == LastCnt) begin
                        o_spr_req <= 1'b0;
                        state_q   <= StDone;
                    end else begin
                        cnt_q      <= cnt_q + 8'd1;
                        o_spr_addr <= {page_q, cnt_q + 8'd1};
                        state_q    <= StRd;
                    end
                end
                StDone: begin
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Directed bench for ppu_oam_dma: memory model, OAM scoreboard, grant drops, retrigger, reset.
// Honours PPU_OAM_DMA_ALIGN_EN by modelling the free-running parity.
module tb_ppu_oam_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bus_addr = 16'h0000;
    logic        bus_wn = 1'b1;
    logic [7:0]  bus_wdata = 8'h00;
    logic [7:0]  oam_base = 8'h00;
    logic        spr_req;
    logic        spr_gnt = 1'b1;
    logic [15:0] spr_addr;
    logic        spr_wn;
    logic [7:0]  spr_wdata;
    logic [7:0]  spr_rdata = 8'h00;
    logic [7:0]  oam_addr;
    logic        oam_we;
    logic [7:0]  oam_wdata;
    logic        busy;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0]  oam [256];
    int unsigned we_cnt, busy_cnt;
    logic [7:0]  first_addr, first_data, data_at_00;
    logic        got_first;
    logic        par, req_par, busy_prev;

    ppu_oam_dma dut (
        .i_cpu_clk   (clk),
        .i_cpu_rstn  (rst_n),
        .i_bus_addr  (bus_addr),
        .i_bus_wn    (bus_wn),
        .i_bus_wdata (bus_wdata),
        .i_oam_base  (oam_base),
        .o_spr_req   (spr_req),
        .i_spr_gnt   (spr_gnt),
        .o_spr_addr  (spr_addr),
        .o_spr_wn    (spr_wn),
        .o_spr_wdata (spr_wdata),
        .i_spr_rdata (spr_rdata),
        .o_oam_addr  (oam_addr),
        .o_oam_we    (oam_we),
        .o_oam_wdata (oam_wdata),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [15:0] a);
        return a[7:0] ^ 8'hA5 ^ (a[15:8] ^ 8'h02);
    endfunction

    // Read data valid the cycle after the address.
    always @(posedge clk) spr_rdata <= memf(spr_addr);

    // Reference parity: toggles every clock out of reset, as the ALIGN feature defines it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) par <= 1'b0;
        else        par <= ~par;
    end

    always @(negedge clk) begin
        if (oam_we) begin
            oam[oam_addr] = oam_wdata;
            we_cnt = we_cnt + 1;
            if (!got_first) begin
                first_addr = oam_addr;
                first_data = oam_wdata;
                got_first  = 1'b1;
            end
            if (oam_addr == 8'h00) data_at_00 = oam_wdata;
        end
        if (busy) busy_cnt = busy_cnt + 1;
        if (busy && !busy_prev) req_par = par;
        busy_prev = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sb();
        for (int i = 0; i < 256; i++) oam[i] = 8'hxx;
        we_cnt = 0;
        busy_cnt = 0;
        got_first = 1'b0;
        data_at_00 = 8'hxx;
    endtask

    task automatic trig(input logic [7:0] pg, input logic [7:0] base);
        @(negedge clk);
        bus_addr  = 16'h4014;
        bus_wn    = 1'b0;
        bus_wdata = pg;
        oam_base  = base;
        @(negedge clk);
        bus_wn   = 1'b1;
        bus_addr = 16'h0000;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
        chk("done_timeout", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_cnt(input logic [7:0] c);
        for (int i = 0; i < 2000 && !(busy && spr_addr[7:0] == c); i++) @(negedge clk);
        chk("cnt_timeout", {24'd0, spr_addr[7:0]}, {24'd0, c});
    endtask

    function automatic int unsigned oam_errs(input logic [7:0] pg, input logic [7:0] base);
        int unsigned e = 0;
        logic [7:0] n8;
        logic [7:0] idx;
        for (int n = 0; n < 256; n++) begin
            n8  = 8'(n);
            idx = base + n8;
            if (oam[idx] !== memf({pg, n8})) e++;
        end
        return e;
    endfunction

    function automatic int unsigned extra();
`ifdef PPU_OAM_DMA_ALIGN_EN
        return {31'd0, req_par};
`else
        return 0;
`endif
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, spr_req}, 32'd0);
        chk({tag, "_addr"},  {16'd0, spr_addr}, 32'd0);
        chk({tag, "_wn"},    {31'd0, spr_wn}, 32'd1);
        chk({tag, "_wdata"}, {24'd0, spr_wdata}, 32'd0);
        chk({tag, "_oaddr"}, {24'd0, oam_addr}, 32'd0);
        chk({tag, "_we"},    {31'd0, oam_we}, 32'd0);
        chk({tag, "_odata"}, {24'd0, oam_wdata}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int unsigned gap_we, gap_addr;
        busy_prev = 1'b0;
        req_par   = 1'b0;
        clear_sb();

        // Reset values.
        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: page 02, base 00, grant tied high.
        clear_sb();
        trig(8'h02, 8'h00);
        chk("t1_busy_rise", {31'd0, busy}, 32'd1);
        chk("t1_req_rise", {31'd0, spr_req}, 32'd1);
        wait_idle();
        chk("t1_oam_errs", oam_errs(8'h02, 8'h00), 32'd0);
        chk("t1_we_cnt", we_cnt, 32'd256);
        chk("t1_busy_cnt", busy_cnt, 514 + extra());
        chk("t1_first_data", {24'd0, first_data}, 32'hA5);

        // 1b: same transfer offset by one cycle so both parities are seen.
        clear_sb();
        @(negedge clk);
        trig(8'h02, 8'h00);
        wait_idle();
        chk("t1b_oam_errs", oam_errs(8'h02, 8'h00), 32'd0);
        chk("t1b_busy_cnt", busy_cnt, 514 + extra());

        // 2: base F0 wraps OAM address.
        clear_sb();
        trig(8'h03, 8'hF0);
        wait_idle();
        chk("t2_first_addr", {24'd0, first_addr}, 32'hF0);
        chk("t2_first_data", {24'd0, first_data}, 32'hA4);
        chk("t2_data_at_00", {24'd0, data_at_00}, 32'hB4);
        chk("t2_oam_errs", oam_errs(8'h03, 8'hF0), 32'd0);
        chk("t2_we_cnt", we_cnt, 32'd256);

        // 3: grant drops for 5 cycles at cnt 40.
        clear_sb();
        trig(8'h02, 8'h00);
        wait_cnt(8'h40);
        spr_gnt  = 1'b0;
        gap_we   = 0;
        gap_addr = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (oam_we) gap_we++;
            if (spr_addr != 16'h0240) gap_addr++;
        end
        chk("t3_gap_req", {31'd0, spr_req}, 32'd1);
        spr_gnt = 1'b1;
        chk("t3_gap_we", gap_we, 32'd0);
        chk("t3_gap_addr", gap_addr, 32'd0);
        wait_idle();
        chk("t3_oam_errs", oam_errs(8'h02, 8'h00), 32'd0);
        chk("t3_we_cnt", we_cnt, 32'd256);
        chk("t3_busy_cnt", busy_cnt, 519 + extra());

        // 4: retrigger at cnt 80 is ignored.
        clear_sb();
        trig(8'h02, 8'h00);
        wait_cnt(8'h80);
        trig(8'h07, 8'h33);
        chk("t4_page", {24'd0, spr_addr[15:8]}, 32'h02);
        wait_idle();
        chk("t4_oam_errs", oam_errs(8'h02, 8'h00), 32'd0);
        chk("t4_we_cnt", we_cnt, 32'd256);

        // 5: reset mid-transfer, then a fresh transfer from cnt 0.
        clear_sb();
        trig(8'h05, 8'h00);
        wait_cnt(8'h10);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("t5");
        @(negedge clk);
        rst_n = 1'b1;
        clear_sb();
        trig(8'h03, 8'h00);
        chk("t5_restart_addr", {16'd0, spr_addr}, 32'h0000);
        wait_idle();
        chk("t5_first_addr", {24'd0, first_addr}, 32'h00);
        chk("t5_first_data", {24'd0, first_data}, 32'hA4);
        chk("t5_we_cnt", we_cnt, 32'd256);

        // 7: trigger in DONE ignored, trigger on the return to IDLE accepted.
        clear_sb();
        trig(8'h02, 8'h00);
        for (int i = 0; i < 2000 && !(busy && !spr_req); i++) @(negedge clk);
        chk("t7_in_done", {30'd0, busy, spr_req}, 32'h2);
        bus_addr  = 16'h4014;
        bus_wn    = 1'b0;
        bus_wdata = 8'h03;
        oam_base  = 8'h00;
        @(negedge clk);
        chk("t7_done_ignored", {31'd0, busy}, 32'd0);
        @(negedge clk);
        bus_wn   = 1'b1;
        bus_addr = 16'h0000;
        chk("t7_idle_accepted", {31'd0, busy}, 32'd1);
        clear_sb();
        wait_idle();
        chk("t7_oam_errs", oam_errs(8'h03, 8'h00), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
